// File: rtl/image_serializer_pkg.sv
// Shared definitions for the obstacle-mask image serializer.
// The frame geometry matches the companion word-to-frame packer.
package image_serializer_pkg;

  localparam int IMG_BITS  = 2500;
  localparam int BUS_W     = 32;
  localparam int IMG_WORDS = (IMG_BITS + BUS_W - 1) / BUS_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage : image_serializer_pkg

// File: rtl/image_serializer.sv
// image_serializer: captures one full image frame and streams it out MSB-first
// as WORD_W-bit words on a valid/ready stream with a last flag. The frame is
// zero-padded at the LSB end up to a whole number of words.
module image_serializer
  import image_serializer_pkg::*;
#(
  parameter int TOTAL_BITS = IMG_BITS,
  parameter int WORD_W     = BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_collision_state,
  input  logic [TOTAL_BITS-1:0] frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [WORD_W-1:0]     data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  data_last,
  output logic [$clog2((TOTAL_BITS + WORD_W - 1) / WORD_W)-1:0] word_idx,
  output logic                  frame_done
);

  // Derived geometry; a frame must span at least two words.
  localparam int NUM_WORDS = (TOTAL_BITS + WORD_W - 1) / WORD_W;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam int PAD_W     = NUM_WORDS * WORD_W;
  localparam int PAD_BITS  = PAD_W - TOTAL_BITS;

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(NUM_WORDS - 2);
  localparam logic [CNT_W-1:0] IDX_ONE    = CNT_W'(1);

  state_t             state_r;
  // Holds the words not yet presented on data_out, next word at the top.
  logic [PAD_W-1:0]   shreg_r;

  logic [PAD_W-1:0]   padded_s;
  logic               frame_hs_s;
  logic               word_hs_s;
  logic               last_word_s;

  // Handshake decode and zero-padded view of the incoming frame.
  always_comb begin
    padded_s    = PAD_W'(frame_in) << PAD_BITS;
    frame_hs_s  = 1'b0;
    word_hs_s   = 1'b0;
    last_word_s = 1'b0;
    if (state_r == ST_IDLE) begin
      frame_hs_s = frame_valid && !in_collision_state;
    end else begin
      word_hs_s   = data_valid && data_ready;
      last_word_s = (word_idx == LAST_IDX);
    end
  end

  // New frames are refused while sending or while the core is mid-collision.
  assign frame_ready = (state_r == ST_IDLE) && !in_collision_state;

  // Serializer state machine with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      word_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (frame_hs_s) begin
            // Word 0 goes straight to the output; the rest wait in the shifter.
            data_out   <= padded_s[PAD_W-1 -: WORD_W];
            shreg_r    <= padded_s << WORD_W;
            data_valid <= 1'b1;
            data_last  <= 1'b0;
            word_idx   <= '0;
            state_r    <= ST_SEND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (word_hs_s) begin
            if (last_word_s) begin
              data_valid <= 1'b0;
              data_last  <= 1'b0;
              word_idx   <= '0;
              frame_done <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              data_out  <= shreg_r[PAD_W-1 -: WORD_W];
              shreg_r   <= shreg_r << WORD_W;
              word_idx  <= word_idx + IDX_ONE;
              data_last <= (word_idx == PENULT_IDX);
              state_r   <= ST_SEND;
            end
          end else begin
            // Stalled: hold the presented word.
            state_r <= ST_SEND;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          data_valid <= 1'b0;
          data_last  <= 1'b0;
          word_idx   <= '0;
        end
      endcase
    end
  end

endmodule : image_serializer

// File: tb/tb_image_serializer.sv
// Self-checking bench for image_serializer: random frames, a reference model
// that slices the zero-padded frame directly, and scenario tasks.
module tb_image_serializer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_collision_state = 1'b0;
  logic [2499:0] frame_in = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [31:0]   data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          data_last;
  logic [6:0]    word_idx;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  image_serializer dut (
    .clk                (clk),
    .rst                (rst),
    .in_collision_state (in_collision_state),
    .frame_in           (frame_in),
    .frame_valid        (frame_valid),
    .frame_ready        (frame_ready),
    .data_out           (data_out),
    .data_valid         (data_valid),
    .data_ready         (data_ready),
    .data_last          (data_last),
    .word_idx           (word_idx),
    .frame_done         (frame_done)
  );

  always #5 clk = ~clk;

  // Reference: word k is bits [2527-32k -: 32] of {frame, 28'b0}.
  function automatic logic [31:0] exp_word(input logic [2499:0] f, input int k);
    logic [2527:0] p;
    p = {f, 28'h0};
    return p[2527 - 32*k -: 32];
  endfunction

  task automatic rand_frame(output logic [2499:0] f);
    logic [2527:0] t;
    for (int i = 0; i < 79; i++) t[i*32 +: 32] = $urandom;
    f = t[2499:0];
  endtask

  // Offer a frame at a negedge; returns at the negedge after the capture edge.
  task automatic start_frame(input logic [2499:0] f);
    frame_in    = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // Consume a frame whose word 0 is already visible. hook_kind at word hook_k:
  // 1 = raise collision, 2 = offer frame f2, 3 = assert reset and return.
  task automatic run_stream(input logic [2499:0] f, input bit rand_ready,
                            input int hook_k, input int hook_kind,
                            input logic [2499:0] f2, output int hs, output int cycles);
    logic [2527:0] rebuilt;
    logic [31:0]   prev_out;
    logic [6:0]    prev_idx;
    bit            stalled;
    hs = 0; cycles = 0; stalled = 0; rebuilt = '0; prev_out = '0; prev_idx = '0;
    while (hs < 79 && cycles < 4000) begin
      if (hs == hook_k && hook_kind == 1) in_collision_state = 1'b1;
      if (hs == hook_k && hook_kind == 2) begin frame_in = f2; frame_valid = 1'b1; end
      if (hs == hook_k && hook_kind == 3) begin
        rst = 1'b1; data_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      #1;
      checks++;
      if (data_valid !== 1'b1) begin
        failures++; $display("FAIL stream_valid word=%0d got=%b want=1", hs, data_valid);
      end
      checks++;
      if (word_idx !== 7'(hs)) begin
        failures++; $display("FAIL stream_idx got=%0d want=%0d", word_idx, hs);
      end
      checks++;
      if (data_out !== exp_word(f, hs)) begin
        failures++; $display("FAIL stream_data word=%0d got=%h want=%h", hs, data_out, exp_word(f, hs));
      end
      checks++;
      if (data_last !== (hs == 78)) begin
        failures++; $display("FAIL stream_last word=%0d got=%b want=%b", hs, data_last, hs == 78);
      end
      checks++;
      if (frame_done !== 1'b0 || frame_ready !== 1'b0) begin
        failures++; $display("FAIL stream_ctl word=%0d done=%b ready=%b want 0 0", hs, frame_done, frame_ready);
      end
      if (stalled) begin
        checks++;
        if (data_out !== prev_out || word_idx !== prev_idx) begin
          failures++; $display("FAIL stall_stable got=%h/%0d want=%h/%0d", data_out, word_idx, prev_out, prev_idx);
        end
      end
      data_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      prev_out = data_out;
      prev_idx = word_idx;
      if (data_ready) begin
        rebuilt[2527 - 32*hs -: 32] = data_out;
        hs++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      cycles++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (hs != 79) begin
      failures++; $display("FAIL stream_timeout handshakes=%0d want=79", hs);
    end
    checks++;
    if (frame_done !== 1'b1 || data_valid !== 1'b0 || data_last !== 1'b0 || word_idx !== 7'd0) begin
      failures++; $display("FAIL stream_end done=%b valid=%b last=%b idx=%0d want 1 0 0 0",
                           frame_done, data_valid, data_last, word_idx);
    end
    checks++;
    if (frame_ready !== !in_collision_state) begin
      failures++; $display("FAIL end_ready got=%b want=%b", frame_ready, !in_collision_state);
    end
    checks++;
    if (rebuilt[2527:28] !== f || rebuilt[27:0] !== 28'h0) begin
      failures++; $display("FAIL reassemble top_got=%h top_want=%h", rebuilt[2527:2496], f[2499:2468]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (data_out !== 32'h0 || data_valid !== 1'b0 || data_last !== 1'b0 ||
        word_idx !== 7'd0 || frame_done !== 1'b0 || frame_ready !== 1'b1) begin
      failures++; $display("FAIL reset_state out=%h v=%b l=%b idx=%0d d=%b r=%b want 0 0 0 0 0 1",
                           data_out, data_valid, data_last, word_idx, frame_done, frame_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b0 || frame_done !== 1'b0) begin
        failures++; $display("FAIL idle_quiet cyc=%0d valid=%b done=%b want 0 0", i, data_valid, frame_done);
      end
    end
  endtask

  task automatic test_full_stream();
    logic [2499:0] f;
    int hs, cyc;
    for (int i = 0; i < 2500; i++) f[i] = 1'((i / 7) ^ (i >> 3));
    start_frame(f);
    run_stream(f, 1'b0, -1, 0, f, hs, cyc);
    checks++;
    if (cyc != 79) begin
      failures++; $display("FAIL full_throughput cycles=%0d want=79", cyc);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL done_pulse_width got=%b want=0", frame_done);
    end
  endtask

  task automatic test_backpressure();
    logic [2499:0] f;
    int hs, cyc;
    for (int n = 0; n < 3; n++) begin
      rand_frame(f);
      start_frame(f);
      run_stream(f, 1'b1, -1, 0, f, hs, cyc);
      data_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_collision();
    logic [2499:0] f;
    int hs, cyc;
    rand_frame(f);
    in_collision_state = 1'b1;
    frame_in = f;
    frame_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (frame_ready !== 1'b0 || data_valid !== 1'b0) begin
        failures++; $display("FAIL collision_gate cyc=%0d ready=%b valid=%b want 0 0", i, frame_ready, data_valid);
      end
      @(negedge clk);
    end
    in_collision_state = 1'b0;
    #1;
    checks++;
    if (frame_ready !== 1'b1) begin
      failures++; $display("FAIL collision_release ready=%b want=1", frame_ready);
    end
    @(negedge clk);
    frame_valid = 1'b0;
    run_stream(f, 1'b1, 40, 1, f, hs, cyc);
    in_collision_state = 1'b0;
    data_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_during_send();
    logic [2499:0] f1, f2;
    int hs, cyc;
    rand_frame(f1);
    rand_frame(f2);
    start_frame(f1);
    run_stream(f1, 1'b0, 10, 2, f2, hs, cyc);
    @(negedge clk);
    frame_valid = 1'b0;
    #1;
    checks++;
    if (data_valid !== 1'b1 || word_idx !== 7'd0 || data_out !== exp_word(f2, 0) || frame_done !== 1'b0) begin
      failures++; $display("FAIL second_frame_start valid=%b idx=%0d data=%h want 1 0 %h",
                           data_valid, word_idx, data_out, exp_word(f2, 0));
    end
    run_stream(f2, 1'b1, -1, 0, f2, hs, cyc);
    data_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [2499:0] f;
    int hs, cyc;
    rand_frame(f);
    start_frame(f);
    run_stream(f, 1'b0, 30, 3, f, hs, cyc);
    #1;
    checks++;
    if (data_valid !== 1'b0 || word_idx !== 7'd0 || frame_done !== 1'b0 || data_last !== 1'b0) begin
      failures++; $display("FAIL reset_mid valid=%b idx=%0d done=%b last=%b want 0 0 0 0",
                           data_valid, word_idx, frame_done, data_last);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || data_valid !== 1'b0 || frame_ready !== 1'b1) begin
      failures++; $display("FAIL reset_after done=%b valid=%b ready=%b want 0 0 1",
                           frame_done, data_valid, frame_ready);
    end
    rand_frame(f);
    start_frame(f);
    run_stream(f, 1'b1, -1, 0, f, hs, cyc);
    data_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_full_stream();
    test_backpressure();
    test_collision();
    test_frame_during_send();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout reached time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_image_serializer
